// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported unified memory between the
//                instruction-fetch and memory-access stages. Data requests
//                win by default; after FAIR_LIMIT consecutive data grants
//                taken while fetch was waiting, fetch is forced through.
//                Memory side is a variable-latency valid/ack handshake.
//                Optional feature macro: MEM_ARB_TIMEOUT_EN (abort a memory
//                access after TIMEOUT cycles without ack, return a NOP and
//                raise the sticky err flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    // Must be at least 1; fetch is forced through after this many data wins.
    parameter int FAIR_LIMIT = 3
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    // memory side
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    // status
    output logic        err
);

    localparam int                    c_FAIR_W   = $clog2(FAIR_LIMIT + 1);
    localparam logic [c_FAIR_W-1:0]   c_FAIR_MAX = c_FAIR_W'(FAIR_LIMIT);
    localparam logic [c_FAIR_W-1:0]   c_FAIR_ONE = c_FAIR_W'(1);
    localparam logic [31:0]           c_NOP      = 32'h0000_0013;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    logic [1:0]          r_state;
    logic [c_FAIR_W-1:0] r_fairCnt;
    logic                r_memValid;
    logic                r_memWe;
    logic [31:0]         r_memAddr;
    logic [31:0]         r_memWdata;
    logic [31:0]         r_iRdata;
    logic [31:0]         r_dRdata;
    logic                r_iReady;
    logic                r_dReady;

    logic                w_grantD;
    logic                w_grantI;
    logic                w_abort;
    logic                w_done;

    // Grant decision, only meaningful while idle: data wins unless fetch is
    // also waiting and data has already used up its fairness allowance.
    always_comb begin
        w_grantD = 1'b0;
        w_grantI = 1'b0;
        if (r_state == c_IDLE) begin
            if (d_req && (!i_req || (r_fairCnt < c_FAIR_MAX))) begin
                w_grantD = 1'b1;
            end else if (i_req) begin
                w_grantI = 1'b1;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    logic [c_WAIT_W-1:0] r_waitCnt;
    logic                r_err;

    // The abort fires on the TIMEOUT-th busy cycle that passes without ack.
    assign w_abort = (r_state != c_IDLE) && !mem_ack && (r_waitCnt == c_WAIT_LAST);

    // Busy-cycle counter, restarted on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt <= '0;
        end else if (w_grantD || w_grantI) begin
            r_waitCnt <= '0;
        end else if ((r_state != c_IDLE) && !w_abort) begin
            r_waitCnt <= r_waitCnt + c_WAIT_ONE;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    // A busy transaction ends either on ack or on a timeout abort.
    assign w_done = mem_ack || w_abort;

    // Main arbiter FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_fairCnt  <= '0;
            r_memValid <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_iRdata   <= '0;
            r_dRdata   <= '0;
            r_iReady   <= 1'b0;
            r_dReady   <= 1'b0;
        end else begin
            r_iReady <= 1'b0;
            r_dReady <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // Any ack seen here is stale or spurious and is dropped.
                    if (w_grantD) begin
                        r_state    <= c_BUSY_D;
                        r_memValid <= 1'b1;
                        r_memWe    <= d_we;
                        r_memAddr  <= d_addr;
                        r_memWdata <= d_wdata;
                        // Only data wins taken over a waiting fetch count
                        // toward the fairness limit; the compare above keeps
                        // this from passing FAIR_LIMIT.
                        r_fairCnt  <= i_req ? (r_fairCnt + c_FAIR_ONE) : '0;
                    end else if (w_grantI) begin
                        r_state    <= c_BUSY_I;
                        r_memValid <= 1'b1;
                        r_memWe    <= 1'b0;
                        r_memAddr  <= i_addr;
                        r_memWdata <= '0;
                        r_fairCnt  <= '0;
                    end
                end
                c_BUSY_I: begin
                    if (w_done) begin
                        r_iRdata   <= mem_ack ? mem_rdata : c_NOP;
                        r_iReady   <= 1'b1;
                        r_memValid <= 1'b0;
                        r_memWe    <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end
                c_BUSY_D: begin
                    if (w_done) begin
                        // Stores leave the last load result in place.
                        if (!r_memWe) begin
                            r_dRdata <= mem_ack ? mem_rdata : c_NOP;
                        end
                        r_dReady   <= 1'b1;
                        r_memValid <= 1'b0;
                        r_memWe    <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_memValid <= 1'b0;
                    r_memWe    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_valid = r_memValid;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign i_rdata   = r_iRdata;
    assign i_ready   = r_iReady;
    assign d_rdata   = r_dRdata;
    assign d_ready   = r_dReady;

endmodule
`default_nettype wire
